// File: rtl/tcm_arb_pkg.sv
// Shared definitions for the IFU/MAU TCM arbiter: AHB transfer encodings,
// data-phase owner encoding and the held-response record.
package tcm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_MAU = 1'b1;

  // Width of the held read word; the arbiter's DW must not exceed it.
  localparam int unsigned HOLD_DW = 32;

  typedef struct packed {
    logic               resp;
    logic [HOLD_DW-1:0] data;
  } hold_t;

endpackage

// File: rtl/tcm_arb_resp_hold.sv
// Per-master response path: parks a completed data phase while the master's
// next address phase is still waiting for a grant, presents the parked
// response, and generates the master's hready.
module tcm_arb_resp_hold
  import tcm_arb_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          hclk,
  input  logic          hrst,
  input  logic          tcm_hready,
  input  logic          tcm_hresp,
  input  logic [DW-1:0] tcm_hrdata,
  input  logic          req,
  input  logic          gnt,
  input  logic          dph,
  output logic          hready,
  output logic          hresp,
  output logic [DW-1:0] hrdata
);

  logic  hold_vld;
  hold_t hold_q;

  // Capture when our data phase ends but our next request lost arbitration;
  // release on the cycle that request is finally accepted.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      hold_vld <= 1'b0;
      hold_q   <= '0;
    end else if (tcm_hready) begin
      if (dph && req && !gnt) begin
        hold_vld    <= 1'b1;
        hold_q.resp <= tcm_hresp;
        hold_q.data <= HOLD_DW'(tcm_hrdata);
      end else if (hold_vld && gnt) begin
        hold_vld <= 1'b0;
      end
    end
  end

  // A pending request or parked response stalls until granted; otherwise
  // follow the slave during our own data phase.
  always_comb begin
    hready = 1'b1;
    if (hold_vld || req) hready = gnt & tcm_hready;
    else if (dph)        hready = tcm_hready;
  end

  assign hrdata = hold_vld ? DW'(hold_q.data) : tcm_hrdata;
  assign hresp  = hold_vld ? hold_q.resp : (dph & tcm_hresp);

endmodule

// File: rtl/tcm_ahb_arbiter.sv
// Two-master AHB-lite arbiter sharing one TCM port between IFU (fetch) and
// MAU (load/store). MAU wins on contention. Defining TCM_ARB_STARVE_GUARD_EN
// adds a streak counter that forces one IFU grant after MAU_STREAK_MAX
// consecutive MAU wins over a waiting IFU.
module tcm_ahb_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned MAU_STREAK_MAX = 4
) (
  input  logic          hclk,
  input  logic          hrst,
  input  logic [AW-1:0] ifu_haddr,
  input  logic [1:0]    ifu_htrans,
  input  logic [2:0]    ifu_hsize,
  output logic          ifu_hready,
  output logic          ifu_hresp,
  output logic [DW-1:0] ifu_hrdata,
  input  logic [AW-1:0] mau_haddr,
  input  logic [1:0]    mau_htrans,
  input  logic          mau_hwrite,
  input  logic [2:0]    mau_hsize,
  input  logic [DW-1:0] mau_hwdata,
  output logic          mau_hready,
  output logic          mau_hresp,
  output logic [DW-1:0] mau_hrdata,
  output logic [AW-1:0] tcm_haddr,
  output logic [1:0]    tcm_htrans,
  output logic          tcm_hwrite,
  output logic [2:0]    tcm_hsize,
  output logic [DW-1:0] tcm_hwdata,
  input  logic          tcm_hready,
  input  logic          tcm_hresp,
  input  logic [DW-1:0] tcm_hrdata,
  output logic          arb_dph_vld,
  output logic          arb_dph_own
);

  logic req_i, req_m, gnt_i, gnt_m, guard_trip, dph_i, dph_m;

  assign req_i = ifu_htrans[1];
  assign req_m = mau_htrans[1];

`ifdef TCM_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = (MAU_STREAK_MAX < 1) ? 1 : $clog2(MAU_STREAK_MAX + 1);
  logic [SW-1:0] streak;

  // Count MAU wins over a waiting IFU; an IFU win or an idle IFU restarts it.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      streak <= '0;
    end else if (tcm_hready) begin
      if (!req_i || gnt_i) streak <= '0;
      else if (gnt_m)      streak <= streak + SW'(1);
    end
  end

  assign guard_trip = req_i && (streak == SW'(MAU_STREAK_MAX));
`else
  assign guard_trip = 1'b0;
`endif

  assign gnt_m = req_m & ~guard_trip;
  assign gnt_i = req_i & ~gnt_m;

  // Forward the granted master's address phase; idle the slave otherwise.
  always_comb begin
    tcm_haddr  = '0;
    tcm_htrans = IDLE;
    tcm_hwrite = 1'b0;
    tcm_hsize  = '0;
    if (gnt_m) begin
      tcm_haddr  = mau_haddr;
      tcm_htrans = mau_htrans;
      tcm_hwrite = mau_hwrite;
      tcm_hsize  = mau_hsize;
    end else if (gnt_i) begin
      tcm_haddr  = ifu_haddr;
      tcm_htrans = ifu_htrans;
      tcm_hsize  = ifu_hsize;
    end
  end

  // Track which master owns the slave's current data phase.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      arb_dph_vld <= 1'b0;
      arb_dph_own <= OWN_IFU;
    end else if (tcm_hready) begin
      arb_dph_vld <= gnt_i | gnt_m;
      arb_dph_own <= gnt_m ? OWN_MAU : OWN_IFU;
    end
  end

  assign dph_i      = arb_dph_vld & (arb_dph_own == OWN_IFU);
  assign dph_m      = arb_dph_vld & (arb_dph_own == OWN_MAU);
  assign tcm_hwdata = dph_m ? mau_hwdata : '0;

  tcm_arb_resp_hold #(.DW(DW)) u_hold_ifu (
    .hclk       (hclk),
    .hrst       (hrst),
    .tcm_hready (tcm_hready),
    .tcm_hresp  (tcm_hresp),
    .tcm_hrdata (tcm_hrdata),
    .req        (req_i),
    .gnt        (gnt_i),
    .dph        (dph_i),
    .hready     (ifu_hready),
    .hresp      (ifu_hresp),
    .hrdata     (ifu_hrdata)
  );

  tcm_arb_resp_hold #(.DW(DW)) u_hold_mau (
    .hclk       (hclk),
    .hrst       (hrst),
    .tcm_hready (tcm_hready),
    .tcm_hresp  (tcm_hresp),
    .tcm_hrdata (tcm_hrdata),
    .req        (req_m),
    .gnt        (gnt_m),
    .dph        (dph_m),
    .hready     (mau_hready),
    .hresp      (mau_hresp),
    .hrdata     (mau_hrdata)
  );

endmodule
